// File: rtl/time_display_driver.sv
// MM:SS driver for a 4-digit common-anode seven-segment display fed by a seconds count.
// Define TIME_DISPLAY_LZ_BLANK_EN to blank the minute-tens digit when it is zero.
module time_display_driver #(
  parameter int TIMER_WIDTH = 16,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TIMER_WIDTH-1:0] i_current_time,
  input  logic                   i_blank,
  output logic [6:0]             o_seg,
  output logic                   o_dp,
  output logic [3:0]             o_an,
  output logic                   o_busy
);

  localparam int SCAN_DIV = CLK_FREQ / (SCAN_HZ * 4);
  localparam int PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV60, S_TENS, S_COMMIT} state_e;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] last_q, last_d;
  logic [TIMER_WIDTH-1:0] work_q, work_d;
  logic [6:0]             min_q, min_d, sec_q, sec_d;
  logic [3:0]             mt_q, mt_d, st_q, st_d;
  logic [3:0][3:0]        disp_q, disp_d;
  logic [1:0]             idx_q, idx_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d, busy_q, busy_d;
  logic [3:0]             digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // NOTE: every register, including the digit store, is reset so a mid-conversion reset leaves no stale state.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      work_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      mt_q    <= '0;
      st_q    <= '0;
      disp_q  <= '0;
      idx_q   <= '0;
      presc_q <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
      dp_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      work_q  <= work_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      mt_q    <= mt_d;
      st_q    <= st_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: each always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_current_time != last_q) state_d = S_DIV60;
      S_DIV60:  if (work_q < TIMER_WIDTH'(60) || min_q == 7'd99) state_d = S_TENS;
      S_TENS:   if (min_q < 7'd10 && sec_q < 7'd10) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    work_d = work_q;
    min_d  = min_q;
    sec_d  = sec_q;
    mt_d   = mt_q;
    st_d   = st_q;
    disp_d = disp_q;
    case (state_q)
      S_IDLE: begin
        if (i_current_time != last_q) begin
          last_d = i_current_time;
          work_d = i_current_time;
          min_d  = '0;
          mt_d   = '0;
          st_d   = '0;
        end
      end
      S_DIV60: begin
        if (work_q >= TIMER_WIDTH'(60)) begin
          // Beyond 99 minutes the display pins at 99:59.
          if (min_q == 7'd99) begin
            sec_d = 7'd59;
          end else begin
            work_d = work_q - TIMER_WIDTH'(60);
            min_d  = min_q + 7'd1;
          end
        end else begin
          sec_d = 7'(work_q);
        end
      end
      S_TENS: begin
        if (min_q >= 7'd10) begin
          min_d = min_q - 7'd10;
          mt_d  = mt_q + 4'd1;
        end
        if (sec_q >= 7'd10) begin
          sec_d = sec_q - 7'd10;
          st_d  = st_q + 4'd1;
        end
      end
      S_COMMIT: disp_d = {mt_q, min_q[3:0], st_q, sec_q[3:0]};
      default: ;
    endcase
  end

  always_comb begin
    busy_d  = (state_d != S_IDLE);
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    digit = disp_q[idx_d];
    an_d  = ~(4'b0001 << idx_d);
    seg_d = seg7(digit);
`ifdef TIME_DISPLAY_LZ_BLANK_EN
    if (idx_d == 2'd3 && digit == 4'd0) seg_d = 7'h7F;
`endif
    dp_d = (idx_d != 2'd2);
    if (i_blank) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  assign o_seg  = seg_q;
  assign o_dp   = dp_q;
  assign o_an   = an_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver: vector table, corner sequences and random times.
module tb_time_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_current_time;
  logic        i_blank;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  int  cyc     = 0;
  bit  blank_r = 1'b0;
  bit  mon_en  = 1'b0;
  int  last_t  = 0;

  time_display_driver #(.TIMER_WIDTH(16), .CLK_FREQ(400), .SCAN_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .i_current_time(i_current_time), .i_blank(i_blank),
    .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int mm;
    int ss;
    int cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Reference: minutes/seconds from plain division, saturating at 99:59.
  function automatic void ref_time(input int t, output int mm, output int ss);
    if (t / 60 > 99) begin
      mm = 99; ss = 59;
    end else begin
      mm = t / 60; ss = t % 60;
    end
  endfunction

  function automatic int ref_cycles(input int t);
    int mm, ss, q, tens;
    ref_time(t, mm, ss);
    q    = (t / 60 > 99) ? 99 : t / 60;
    tens = ((mm / 10) > (ss / 10)) ? mm / 10 : ss / 10;
    return (q + 1) + (tens + 1) + 1;
  endfunction

  // Scan position model: idx advances every 10 clocks counted from reset release.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc     <= 0;
      blank_r <= 1'b0;
    end else begin
      cyc     <= cyc + 1;
      blank_r <= i_blank;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int idx;
      idx = (cyc / 10) % 4;
      check("an", o_an, blank_r ? 4'hF : 4'(~(4'b0001 << idx)));
      check("dp", o_dp, blank_r ? 1'b1 : (idx == 2 ? 1'b0 : 1'b1));
      if (blank_r) check("blank_seg", o_seg, 7'h7F);
    end
  end

  task automatic check_digits(input int mm, input int ss);
    int idx, d;
    logic [6:0] exp;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      idx = (cyc / 10) % 4;
      case (idx)
        0:       d = ss % 10;
        1:       d = ss / 10;
        2:       d = mm % 10;
        default: d = mm / 10;
      endcase
      exp = ref_seg(d);
`ifdef TIME_DISPLAY_LZ_BLANK_EN
      if (idx == 3 && d == 0) exp = 7'h7F;
`endif
      check($sformatf("seg_idx%0d_%02d:%02d", idx, mm, ss), o_seg, exp);
    end
  endtask

  task automatic measure_busy(input string name, input int exp);
    int cnt = 0;
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (o_busy) cnt++;
      else if (cnt > 0) done = 1'b1;
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy_cycles"}, cnt, exp);
  endtask

  task automatic run_conv(input int t, input int exp_cycles);
    @(negedge clk);
    i_current_time = 16'(t);
    last_t = t;
    measure_busy($sformatf("conv_%0d", t), exp_cycles);
  endtask

  vec_t vecs [8];

  initial begin
    int mm, ss, t, cnt;
    vecs = '{
      '{125,   2,  5,   5},
      '{59,    0, 59,   8},
      '{60,    1,  0,   4},
      '{3599, 59, 59,  67},
      '{5940, 99,  0, 111},
      '{6000, 99, 59, 111},
      '{65535,99, 59, 111},
      '{0,     0,  0,   3}
    };

    rst_n = 1'b0; i_current_time = '0; i_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_an", o_an, 4'b1110);
    check("rst_seg", o_seg, 7'b1000000);
    check("rst_dp", o_dp, 1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      check("idle_busy", o_busy, 0);
    end
    check_digits(0, 0);

    foreach (vecs[i]) begin
      run_conv(vecs[i].t, vecs[i].cycles);
      check_digits(vecs[i].mm, vecs[i].ss);
    end

    // Input changes while busy: first conversion completes, then the newer value.
    @(negedge clk);
    i_current_time = 16'd125;
    @(negedge clk);
    check("midchg_busy_start", o_busy, 1);
    @(negedge clk);
    i_current_time = 16'd126;
    last_t = 126;
    cnt = 2;
    for (int i = 0; i < 50 && o_busy; i++) begin
      @(negedge clk);
      if (o_busy) cnt++;
    end
    check("midchg_first_cycles", cnt, 5);
    check("midchg_gap", o_busy, 0);
    @(negedge clk);
    check("midchg_restart", o_busy, 1);
    cnt = 1;
    for (int i = 0; i < 50 && o_busy; i++) begin
      @(negedge clk);
      if (o_busy) cnt++;
    end
    check("midchg_second_cycles", cnt, 5);
    check_digits(2, 6);

    // Blanking: the monitor checks anodes/dp; segments checked here too.
    @(negedge clk);
    i_blank = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("blank_on_an", o_an, 4'hF);
    end
    i_blank = 1'b0;
    check_digits(2, 6);

    // Reset mid-DIV60, then the still-nonzero input restarts conversion.
    @(negedge clk);
    i_current_time = 16'd6000;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", o_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", o_busy, 0);
    check("midrst_an", o_an, 4'b1110);
    check("midrst_seg", o_seg, 7'b1000000);
    check("midrst_dp", o_dp, 1);
    measure_busy("restart_6000", 111);
    check_digits(99, 59);
    last_t = 6000;

    run_conv(65, 4);
    check_digits(1, 5);

    for (int i = 0; i < 16; i++) begin
      do begin
        t = (i % 2) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 7000));
      end while (t == last_t);
      ref_time(t, mm, ss);
      run_conv(t, ref_cycles(t));
      check_digits(mm, ss);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
